// File: rtl/exec_std_rv32i.sv
// RV32I execute stage: single-cycle ALU, optional 32-cycle restoring divider.
// Define RV32M_DIV_EN to build the divider; without it opcodes 10-13 report illegal.
module exec_std_rv32i (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        FLUSH,
  input  logic        MEM_WAIT,
  input  logic        I_VALID,
  input  logic [3:0]  I_OP,
  input  logic [4:0]  I_RD,
  input  logic        I_USE_IMM,
  input  logic [31:0] I_IMM,
  input  logic        A_RVALID,
  input  logic        B_RVALID,
  input  logic [31:0] A_RDATA,
  input  logic [31:0] B_RDATA,
  output logic        O_VALID,
  output logic [4:0]  O_RD,
  output logic [31:0] O_DATA,
  output logic        O_ILLEGAL,
  output logic        FWD_EXEC_EN,
  output logic [4:0]  FWD_EXEC_ADDR,
  output logic [31:0] FWD_EXEC_DATA,
  output logic        STALL_REQ
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;
  localparam int unsigned CW   = 5;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_DIV  = 4'd10;
  localparam logic [3:0] OP_DIVU = 4'd11;
  localparam logic [3:0] OP_REM  = 4'd12;
  localparam logic [3:0] OP_REMU = 4'd13;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t          state;
  logic [XLEN-1:0] opb;
  logic [4:0]      shamt;
  logic            opnd_ok;
  logic            accept;
  logic            div_start;
  logic [XLEN-1:0] res;
  logic            ill;

  assign opb       = I_USE_IMM ? I_IMM : B_RDATA;
  assign shamt     = opb[4:0];
  assign opnd_ok   = A_RVALID & (I_USE_IMM | B_RVALID);
  assign accept    = I_VALID & opnd_ok & (state == IDLE) & ~FLUSH & ~MEM_WAIT;
  assign STALL_REQ = (I_VALID & ~opnd_ok) | (state != IDLE);

`ifdef RV32M_DIV_EN
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] dvs;
  logic            is_rem;
  logic            neg_q;
  logic            neg_r;
  logic [RW-1:0]   div_rd;
  logic            op_div;
  logic            op_sgn;
  logic            op_rem;
  logic            div_zero;
  logic            div_ovf;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [XLEN-1:0] div_fast;
  logic [XLEN-1:0] div_res;
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   trial;

  assign op_div    = (I_OP == OP_DIV) | (I_OP == OP_DIVU) | (I_OP == OP_REM) | (I_OP == OP_REMU);
  assign op_sgn    = (I_OP == OP_DIV) | (I_OP == OP_REM);
  assign op_rem    = (I_OP == OP_REM) | (I_OP == OP_REMU);
  assign div_zero  = (opb == '0);
  assign div_ovf   = op_sgn & (A_RDATA == 32'h8000_0000) & (opb == 32'hFFFF_FFFF);
  assign div_start = accept & op_div & ~div_zero & ~div_ovf;
  assign a_mag     = (op_sgn & A_RDATA[XLEN-1]) ? (-A_RDATA) : A_RDATA;
  assign b_mag     = (op_sgn & opb[XLEN-1]) ? (-opb) : opb;

  // Corner cases that finish in the single ALU cycle
  always_comb begin
    div_fast = '0;
    if (div_zero) div_fast = op_rem ? A_RDATA : 32'hFFFF_FFFF;
    else          div_fast = op_rem ? 32'h0000_0000 : 32'h8000_0000;
  end

  // One restoring step: shift in next dividend bit, subtract if it fits
  assign rem_sh  = {rem, quo[XLEN-1]};
  assign trial   = rem_sh - {1'b0, dvs};
  assign div_res = is_rem ? (neg_r ? (-rem) : rem) : (neg_q ? (-quo) : quo);
`else
  assign state     = IDLE;
  assign div_start = 1'b0;
`endif

  always_comb begin
    res = '0;
    ill = 1'b0;
    case (I_OP)
      OP_ADD:  res = A_RDATA + opb;
      OP_SUB:  res = A_RDATA - opb;
      OP_AND:  res = A_RDATA & opb;
      OP_OR:   res = A_RDATA | opb;
      OP_XOR:  res = A_RDATA ^ opb;
      OP_SLL:  res = A_RDATA << shamt;
      OP_SRL:  res = A_RDATA >> shamt;
      OP_SRA:  res = $unsigned($signed(A_RDATA) >>> shamt);
      OP_SLT:  res = XLEN'($signed(A_RDATA) < $signed(opb));
      OP_SLTU: res = XLEN'(A_RDATA < opb);
`ifdef RV32M_DIV_EN
      OP_DIV, OP_DIVU, OP_REM, OP_REMU: res = div_fast;
`endif
      default: ill = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      O_VALID       <= 1'b0;
      O_ILLEGAL     <= 1'b0;
      O_RD          <= '0;
      O_DATA        <= '0;
      FWD_EXEC_EN   <= 1'b0;
      FWD_EXEC_ADDR <= '0;
      FWD_EXEC_DATA <= '0;
`ifdef RV32M_DIV_EN
      state  <= IDLE;
      cnt    <= '0;
      quo    <= '0;
      rem    <= '0;
      dvs    <= '0;
      is_rem <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div_rd <= '0;
`endif
    end else if (FLUSH) begin
      O_VALID     <= 1'b0;
      O_ILLEGAL   <= 1'b0;
      FWD_EXEC_EN <= 1'b0;
`ifdef RV32M_DIV_EN
      state <= IDLE;
`endif
    end else if (!MEM_WAIT) begin
      O_VALID     <= 1'b0;
      O_ILLEGAL   <= 1'b0;
      FWD_EXEC_EN <= 1'b0;
      if (accept && !div_start) begin
        O_VALID       <= 1'b1;
        O_RD          <= I_RD;
        O_DATA        <= res;
        O_ILLEGAL     <= ill;
        FWD_EXEC_EN   <= 1'b1;
        FWD_EXEC_ADDR <= I_RD;
        FWD_EXEC_DATA <= res;
      end
`ifdef RV32M_DIV_EN
      case (state)
        IDLE: if (div_start) begin
          state         <= BUSY;
          cnt           <= CW'(XLEN - 1);
          quo           <= a_mag;
          rem           <= '0;
          dvs           <= b_mag;
          is_rem        <= op_rem;
          neg_q         <= op_sgn & (A_RDATA[XLEN-1] ^ opb[XLEN-1]);
          neg_r         <= op_sgn & A_RDATA[XLEN-1];
          div_rd        <= I_RD;
          FWD_EXEC_ADDR <= I_RD;
        end
        BUSY: begin
          if (!trial[XLEN]) begin
            rem <= trial[XLEN-1:0];
            quo <= {quo[XLEN-2:0], 1'b1};
          end else begin
            rem <= rem_sh[XLEN-1:0];
            quo <= {quo[XLEN-2:0], 1'b0};
          end
          cnt <= cnt - CW'(1);
          if (cnt == '0) state <= DONE;
        end
        DONE: begin
          state         <= IDLE;
          O_VALID       <= 1'b1;
          O_RD          <= div_rd;
          O_DATA        <= div_res;
          FWD_EXEC_EN   <= 1'b1;
          FWD_EXEC_ADDR <= div_rd;
          FWD_EXEC_DATA <= div_res;
        end
        default: state <= IDLE;
      endcase
`endif
    end
  end
endmodule

// File: tb/tb_exec_std_rv32i.sv
// Bench for exec_std_rv32i: randomized instructions with flush/mem-wait injection, scoreboard checked.
module tb_exec_std_rv32i;
  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        FLUSH = 1'b0;
  logic        MEM_WAIT = 1'b0;
  logic        I_VALID = 1'b0;
  logic [3:0]  I_OP = '0;
  logic [4:0]  I_RD = '0;
  logic        I_USE_IMM = 1'b0;
  logic [31:0] I_IMM = '0;
  logic        A_RVALID = 1'b0;
  logic        B_RVALID = 1'b0;
  logic [31:0] A_RDATA = '0;
  logic [31:0] B_RDATA = '0;
  logic        O_VALID;
  logic [4:0]  O_RD;
  logic [31:0] O_DATA;
  logic        O_ILLEGAL;
  logic        FWD_EXEC_EN;
  logic [4:0]  FWD_EXEC_ADDR;
  logic [31:0] FWD_EXEC_DATA;
  logic        STALL_REQ;

  exec_std_rv32i dut (
    .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH), .MEM_WAIT(MEM_WAIT),
    .I_VALID(I_VALID), .I_OP(I_OP), .I_RD(I_RD), .I_USE_IMM(I_USE_IMM), .I_IMM(I_IMM),
    .A_RVALID(A_RVALID), .B_RVALID(B_RVALID), .A_RDATA(A_RDATA), .B_RDATA(B_RDATA),
    .O_VALID(O_VALID), .O_RD(O_RD), .O_DATA(O_DATA), .O_ILLEGAL(O_ILLEGAL),
    .FWD_EXEC_EN(FWD_EXEC_EN), .FWD_EXEC_ADDR(FWD_EXEC_ADDR), .FWD_EXEC_DATA(FWD_EXEC_DATA),
    .STALL_REQ(STALL_REQ)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    bit          ill;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          busy_left = 0;
  int          flush_edge = -1;
  int          mw_lo = -1;
  int          mw_hi = -2;
  logic [4:0]  pend_rd = '0;
  bit          mw_q = 1'b0;
  bit          fl_q = 1'b0;
  bit          mon_en = 1'b0;

  bit          s_valid = 1'b0;
  logic [3:0]  s_op = '0;
  logic [4:0]  s_rd = '0;
  logic [31:0] s_a = '0;
  logic [31:0] s_b = '0;
  bit          s_av = 1'b0;
  bit          s_bv = 1'b0;
  bit          s_ui = 1'b0;
  logic [31:0] s_imm = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Architectural result and latency (in edges, accepting edge included)
  function automatic void ref_exec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] d, output bit ill, output int lat);
    logic [4:0] sh;
    bit sgn, rm;
    sh = b[4:0];
    d = '0;
    ill = 1'b0;
    lat = 1;
    sgn = (op == 4'd10) || (op == 4'd12);
    rm  = (op == 4'd12) || (op == 4'd13);
    case (op)
      4'd0: d = a + b;
      4'd1: d = a - b;
      4'd2: d = a & b;
      4'd3: d = a | b;
      4'd4: d = a ^ b;
      4'd5: d = a << sh;
      4'd6: d = a >> sh;
      4'd7: d = $signed(a) >>> sh;
      4'd8: d = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9: d = (a < b) ? 32'd1 : 32'd0;
`ifdef RV32M_DIV_EN
      4'd10, 4'd11, 4'd12, 4'd13: begin
        if (b == 32'd0) d = rm ? a : 32'hFFFF_FFFF;
        else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) d = rm ? 32'd0 : 32'h8000_0000;
        else begin
          lat = 34;
          if (sgn && rm)  d = $signed(a) % $signed(b);
          else if (sgn)   d = $signed(a) / $signed(b);
          else if (rm)    d = a % b;
          else            d = a / b;
        end
      end
`endif
      default: ill = 1'b1;
    endcase
  endfunction

  always @(posedge CLK) begin
    cyc  <= cyc + 1;
    mw_q <= MEM_WAIT;
    fl_q <= FLUSH;
  end

  // Monitor: compare each fresh output cycle against the scoreboard head
  always @(negedge CLK) begin : monitor
    exp_t e;
    if (mon_en && !(mw_q && !fl_q)) begin
      if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        chk("result_missing_due_edge", 32'(cyc), 32'(exp_q[0].due));
        void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        chk("o_valid", 32'(O_VALID), 32'd1);
        chk("o_rd", 32'(O_RD), 32'(e.rd));
        chk("o_data", O_DATA, e.data);
        chk("o_illegal", 32'(O_ILLEGAL), 32'(e.ill));
        chk("fwd_en", 32'(FWD_EXEC_EN), 32'd1);
        chk("fwd_addr", 32'(FWD_EXEC_ADDR), 32'(e.rd));
        chk("fwd_data", FWD_EXEC_DATA, e.data);
      end else begin
        chk("o_valid_bubble", 32'(O_VALID), 32'd0);
        chk("o_illegal_bubble", 32'(O_ILLEGAL), 32'd0);
        chk("fwd_en_bubble", 32'(FWD_EXEC_EN), 32'd0);
        if (busy_left > 0) chk("fwd_addr_pending", 32'(FWD_EXEC_ADDR), 32'(pend_rd));
      end
    end
  end

  // One clock of stimulus plus the model's view of that edge
  task automatic tick(output bit acc, output bit fl);
    bit mw, miss, ill;
    logic [31:0] d, bop;
    int lat;
    exp_t e;
    @(negedge CLK);
    #1;
    fl = (cyc + 1 == flush_edge);
    mw = (cyc + 1 >= mw_lo) && (cyc + 1 <= mw_hi);
    FLUSH = fl;
    MEM_WAIT = mw;
    I_VALID = s_valid; I_OP = s_op; I_RD = s_rd; I_USE_IMM = s_ui; I_IMM = s_imm;
    A_RVALID = s_av; B_RVALID = s_bv; A_RDATA = s_a; B_RDATA = s_b;
    #1;
    miss = s_valid && (!s_av || (!s_ui && !s_bv));
    chk("stall_req", 32'(STALL_REQ), 32'(miss || busy_left > 0));
    acc = s_valid && !miss && busy_left == 0 && !fl && !mw;
    if (fl) begin
      busy_left = 0;
      for (int i = exp_q.size() - 1; i >= 0; i--)
        if (exp_q[i].due > cyc) exp_q.delete(i);
    end else if (mw) begin
      for (int i = 0; i < exp_q.size(); i++)
        if (exp_q[i].due > cyc) exp_q[i].due = exp_q[i].due + 1;
    end else if (busy_left > 0) begin
      busy_left--;
    end
    if (acc) begin
      bop = s_ui ? s_imm : s_b;
      ref_exec(s_op, s_a, bop, d, ill, lat);
      e.rd = s_rd; e.data = d; e.ill = ill; e.due = cyc + lat;
      exp_q.push_back(e);
      if (lat > 1) begin
        busy_left = 33;
        pend_rd = s_rd;
      end
    end
  endtask

  task automatic run(input logic [3:0] op, input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                     input bit ui, input logic [31:0] imm, input int a_wait, input int b_wait);
    bit acc, fl;
    int n;
    n = 0; acc = 0; fl = 0;
    s_valid = 1'b1; s_op = op; s_rd = rd; s_a = a; s_b = b; s_ui = ui; s_imm = imm;
    while (!acc && !fl && n < 200) begin
      s_av = (n >= a_wait);
      s_bv = (n >= b_wait);
      tick(acc, fl);
      n++;
    end
    if (!acc && !fl) chk("accept_timeout", 32'(n), 32'd0);
    s_valid = 1'b0;
    s_av = 1'($urandom);
    s_bv = 1'($urandom);
  endtask

  task automatic idle(input int n);
    bit acc, fl;
    s_valid = 1'b0;
    repeat (n) tick(acc, fl);
  endtask

  task automatic drain();
    bit acc, fl;
    int n;
    n = 0;
    s_valid = 1'b0;
    while ((exp_q.size() > 0 || busy_left > 0) && n < 300) begin
      tick(acc, fl);
      n++;
    end
    if (n >= 300) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    tick(acc, fl);
  endtask

  task automatic do_reset(input int n);
    mon_en = 1'b0;
    @(negedge CLK);
    #1;
    RST_N = 1'b0; FLUSH = 1'b0; MEM_WAIT = 1'b0; I_VALID = 1'b0; s_valid = 1'b0;
    #1;
    chk("rst_o_valid", 32'(O_VALID), 32'd0);
    chk("rst_o_illegal", 32'(O_ILLEGAL), 32'd0);
    chk("rst_o_rd", 32'(O_RD), 32'd0);
    chk("rst_o_data", O_DATA, 32'd0);
    chk("rst_fwd_en", 32'(FWD_EXEC_EN), 32'd0);
    chk("rst_fwd_addr", 32'(FWD_EXEC_ADDR), 32'd0);
    chk("rst_fwd_data", FWD_EXEC_DATA, 32'd0);
    chk("rst_stall_req", 32'(STALL_REQ), 32'd0);
    repeat (n) @(negedge CLK);
    #1;
    RST_N = 1'b1;
    exp_q.delete();
    busy_left = 0;
    flush_edge = -1;
    mw_lo = -1;
    mw_hi = -2;
    mon_en = 1'b1;
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 9));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] ra, rb, rimm;
    do_reset(3);

    run(4'd0, 5'd1, 32'h7FFF_FFFF, 32'd1, 0, 0, 0, 0);
    run(4'd0, 5'd2, 32'd10, 32'd20, 0, 0, 3, 0);
    run(4'd1, 5'd3, 32'd5, 32'd7, 0, 0, 0, 2);
    run(4'd2, 5'd4, 32'hF0F0_1234, 32'h0FF0_FF00, 0, 0, 0, 0);
    run(4'd3, 5'd5, 32'hF000_0000, 32'h0000_000F, 0, 0, 0, 0);
    run(4'd4, 5'd6, 32'hAAAA_5555, 32'hFFFF_0000, 0, 0, 0, 0);
    run(4'd5, 5'd7, 32'h0000_0001, 32'hFFFF_FFFF, 0, 0, 0, 0);
    run(4'd6, 5'd8, 32'h8000_0000, 32'h0000_0024, 0, 0, 0, 0);
    run(4'd7, 5'd9, 32'h8000_0010, 32'd0, 1, 32'd4, 0, 5);
    run(4'd8, 5'd10, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 0);
    run(4'd9, 5'd11, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 0);
    run(4'd14, 5'd12, 32'd1, 32'd2, 0, 0, 0, 0);
    run(4'd15, 5'd0, 32'd1, 32'd2, 0, 0, 0, 0);
    run(4'd0, 5'd0, 32'd3, 32'd4, 0, 0, 0, 0);
    drain();

    run(4'd10, 5'd13, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, 0);
    run(4'd12, 5'd14, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, 0);
    run(4'd0, 5'd15, 32'd1, 32'd1, 0, 0, 0, 0);
    run(4'd11, 5'd16, 32'd5, 32'd0, 0, 0, 0, 0);
    run(4'd13, 5'd17, 32'd5, 32'd0, 0, 0, 0, 0);
    run(4'd10, 5'd18, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0);
    run(4'd12, 5'd19, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0);
    run(4'd11, 5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0);
    run(4'd10, 5'd21, 32'd100, 32'd0, 1, 32'hFFFF_FFF9, 0, 4);
    drain();

    run(4'd10, 5'd22, 32'd1000, 32'd7, 0, 0, 0, 0);
    flush_edge = cyc + 1 + 10;
    idle(12);
    run(4'd0, 5'd23, 32'd1, 32'd1, 0, 0, 0, 0);
    drain();

    run(4'd13, 5'd24, 32'd12345, 32'd100, 0, 0, 0, 0);
    mw_lo = cyc + 1 + 8;
    mw_hi = mw_lo + 4;
    drain();

    run(4'd10, 5'd25, 32'd77, 32'd5, 0, 0, 0, 0);
    idle(5);
    do_reset(2);
    run(4'd0, 5'd26, 32'd40, 32'd2, 0, 0, 0, 0);
    drain();

    for (int i = 0; i < 250; i++) begin
      ra = pick_val();
      rb = pick_val();
      rimm = pick_val();
      if (flush_edge < cyc && mw_hi < cyc && $urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 1) == 0) flush_edge = cyc + 1 + $urandom_range(0, 30);
        else begin
          mw_lo = cyc + 1 + $urandom_range(0, 30);
          mw_hi = mw_lo + $urandom_range(0, 4);
        end
      end
      run(4'($urandom_range(0, 15)), 5'($urandom), ra, rb, ($urandom_range(0, 3) == 0), rimm,
          ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0,
          ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
